// File: rtl/tri_sched_if.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tri_sched_if : request, TRIANGLE and response signal bundle for tri_sched |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
interface tri_sched_if;
  logic [1:0]  rq_valid;
  logic [1:0]  rq_ready;
  logic [29:0] rq0_coord;
  logic [29:0] rq1_coord;
  logic        tri_in_valid;
  logic [4:0]  tri_coord_x;
  logic [4:0]  tri_coord_y;
  logic        tri_out_valid;
  logic [12:0] tri_out_length;
  logic [12:0] tri_out_incenter;
  logic        rsp_valid;
  logic        rsp_ready;
  logic        rsp_id;
  logic        rsp_err;
  logic [38:0] rsp_length;
  logic [38:0] rsp_incenter;

  // master: the scheduler; slave: requesters, TRIANGLE engine and consumer
  modport master (
    input  rq_valid, rq0_coord, rq1_coord,
    input  tri_out_valid, tri_out_length, tri_out_incenter,
    input  rsp_ready,
    output rq_ready, tri_in_valid, tri_coord_x, tri_coord_y,
    output rsp_valid, rsp_id, rsp_err, rsp_length, rsp_incenter
  );

  modport slave (
    output rq_valid, rq0_coord, rq1_coord,
    output tri_out_valid, tri_out_length, tri_out_incenter,
    output rsp_ready,
    input  rq_ready, tri_in_valid, tri_coord_x, tri_coord_y,
    input  rsp_valid, rsp_id, rsp_err, rsp_length, rsp_incenter
  );
endinterface
`default_nettype wire

// File: rtl/tri_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tri_sched : round-robin two-requester job scheduler for a TRIANGLE core   |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tri_sched #(
  parameter int TIMEOUT = 1023
) (
  input wire          clk,
  input wire          rst_n,
  tri_sched_if.master bus
);

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FEED    = 3'd1,
    S_WAIT    = 3'd2,
    S_COLLECT = 3'd3,
    S_RESP    = 3'd4
  } state_t;

  state_t        state_q, state_d;
  logic          rr_q, rr_d;
  logic          id_q, id_d;
  logic          err_q, err_d;
  logic          tri_in_valid_q, tri_in_valid_d;
  logic          rsp_valid_q, rsp_valid_d;
  logic [29:0]   coord_q, coord_d;
  logic [1:0]    feed_cnt_q, feed_cnt_d;
  logic [1:0]    beat_cnt_q, beat_cnt_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [4:0]    cx_q, cx_d;
  logic [4:0]    cy_q, cy_d;
  logic [38:0]   len_q, len_d;
  logic [38:0]   inc_q, inc_d;

  logic [1:0]    grant;
  logic          win_id;
  logic [29:0]   win_coord;

  // rr_q names the requester that wins when both are valid
  always_comb begin
    grant = 2'b00;
    if (state_q == S_IDLE && rst_n) begin
      unique case (bus.rq_valid)
        2'b01:   grant = 2'b01;
        2'b10:   grant = 2'b10;
        2'b11:   grant = rr_q ? 2'b10 : 2'b01;
        default: grant = 2'b00;
      endcase
    end
  end

  assign win_id    = grant[1];
  assign win_coord = win_id ? bus.rq1_coord : bus.rq0_coord;

  always_comb begin
    state_d        = state_q;
    rr_d           = rr_q;
    id_d           = id_q;
    err_d          = err_q;
    tri_in_valid_d = tri_in_valid_q;
    rsp_valid_d    = rsp_valid_q;
    coord_d        = coord_q;
    feed_cnt_d     = feed_cnt_q;
    beat_cnt_d     = beat_cnt_q;
    tmo_d          = tmo_q;
    cx_d           = cx_q;
    cy_d           = cy_q;
    len_d          = len_q;
    inc_d          = inc_q;

    unique case (state_q)
      S_IDLE: begin
        if (|grant) begin
          state_d        = S_FEED;
          rr_d           = ~win_id;
          id_d           = win_id;
          err_d          = 1'b0;
          coord_d        = win_coord;
          feed_cnt_d     = 2'd1;
          beat_cnt_d     = 2'd0;
          len_d          = '0;
          inc_d          = '0;
          tri_in_valid_d = 1'b1;
          cx_d           = win_coord[29:25];
          cy_d           = win_coord[24:20];
        end
      end

      // feed_cnt_q is the vertex presented in the next cycle
      S_FEED: begin
        unique case (feed_cnt_q)
          2'd1: begin
            cx_d       = coord_q[19:15];
            cy_d       = coord_q[14:10];
            feed_cnt_d = 2'd2;
          end
          2'd2: begin
            cx_d       = coord_q[9:5];
            cy_d       = coord_q[4:0];
            feed_cnt_d = 2'd3;
          end
          default: begin
            cx_d           = 5'd0;
            cy_d           = 5'd0;
            tri_in_valid_d = 1'b0;
            feed_cnt_d     = 2'd0;
            tmo_d          = '0;
            state_d        = S_WAIT;
          end
        endcase
      end

      S_WAIT, S_COLLECT: begin
        tmo_d = tmo_q + 1'b1;
        if (bus.tri_out_valid) begin
          state_d    = S_COLLECT;
          beat_cnt_d = beat_cnt_q + 2'd1;
          unique case (beat_cnt_q)
            2'd0: begin
              len_d[38:26] = bus.tri_out_length;
              inc_d[38:26] = bus.tri_out_incenter;
            end
            2'd1: begin
              len_d[25:13] = bus.tri_out_length;
              inc_d[25:13] = bus.tri_out_incenter;
            end
            default: begin
              len_d[12:0] = bus.tri_out_length;
              inc_d[12:0] = bus.tri_out_incenter;
            end
          endcase
        end
        // a final beat arriving on the timeout cycle still completes cleanly
        if (bus.tri_out_valid && beat_cnt_q == 2'd2) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
        end else if (tmo_q == TMO_LAST) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          err_d       = 1'b1;
        end
      end

      S_RESP: begin
        if (bus.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      rr_q           <= 1'b0;
      id_q           <= 1'b0;
      err_q          <= 1'b0;
      tri_in_valid_q <= 1'b0;
      rsp_valid_q    <= 1'b0;
      coord_q        <= '0;
      feed_cnt_q     <= '0;
      beat_cnt_q     <= '0;
      tmo_q          <= '0;
      cx_q           <= '0;
      cy_q           <= '0;
      len_q          <= '0;
      inc_q          <= '0;
    end else begin
      state_q        <= state_d;
      rr_q           <= rr_d;
      id_q           <= id_d;
      err_q          <= err_d;
      tri_in_valid_q <= tri_in_valid_d;
      rsp_valid_q    <= rsp_valid_d;
      coord_q        <= coord_d;
      feed_cnt_q     <= feed_cnt_d;
      beat_cnt_q     <= beat_cnt_d;
      tmo_q          <= tmo_d;
      cx_q           <= cx_d;
      cy_q           <= cy_d;
      len_q          <= len_d;
      inc_q          <= inc_d;
    end
  end

  assign bus.rq_ready     = grant;
  assign bus.tri_in_valid = tri_in_valid_q;
  assign bus.tri_coord_x  = cx_q;
  assign bus.tri_coord_y  = cy_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_id       = id_q;
  assign bus.rsp_err      = err_q;
  assign bus.rsp_length   = len_q;
  assign bus.rsp_incenter = inc_q;

endmodule
`default_nettype wire

// File: tb/tb_tri_sched.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_tri_sched : directed self-checking bench for tri_sched (TIMEOUT = 16)  |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_tri_sched;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  tri_sched_if bus ();

  tri_sched #(.TIMEOUT(16)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [29:0] RQ0 = {5'd1, 5'd2, 5'd10, 5'd2, 5'd1, 5'd12};
  localparam logic [29:0] RQ1 = {5'd3, 5'd4, 5'd20, 5'd5, 5'd7, 5'd30};

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero_outputs(input string pfx);
    chk({pfx, "_rq_ready"},     bus.rq_ready, 2'b00);
    chk({pfx, "_tri_in_valid"}, bus.tri_in_valid, 1'b0);
    chk({pfx, "_tri_xy"},       {bus.tri_coord_x, bus.tri_coord_y}, 10'd0);
    chk({pfx, "_rsp_valid"},    bus.rsp_valid, 1'b0);
    chk({pfx, "_rsp_id"},       bus.rsp_id, 1'b0);
    chk({pfx, "_rsp_err"},      bus.rsp_err, 1'b0);
    chk({pfx, "_rsp_length"},   bus.rsp_length, 39'd0);
    chk({pfx, "_rsp_incenter"}, bus.rsp_incenter, 39'd0);
  endtask

  // One job from the accept cycle to the response handshake. TRIANGLE model:
  // out_valid pattern bit j is driven in cycle 4+lat+j after the accept cycle.
  task automatic job(input logic [1:0] vld, input logic [4:0] pat, input int plen,
                     input int lat, input int exp_k, input logic exp_id,
                     input logic exp_err, input int hold, input logic [12:0] base);
    logic [29:0] c;
    logic [38:0] el;
    logic [38:0] ei;
    logic [12:0] lv;
    logic [12:0] iv;
    logic [9:0]  v;
    int          b;
    int          k;
    int          j;
    c  = exp_id ? RQ1 : RQ0;
    el = '0;
    ei = '0;
    b  = 0;
    bus.rq_valid = vld;
    #1;
    chk("rq_ready_grant", bus.rq_ready, exp_id ? 2'b10 : 2'b01);
    tick();
    chk("rq_ready_busy", bus.rq_ready, 2'b00);
    k = 1;
    while (k < 60 && bus.rsp_valid !== 1'b1) begin
      if (k <= 3) begin
        v = (k == 1) ? c[29:20] : (k == 2) ? c[19:10] : c[9:0];
        chk("tri_in_valid_on", bus.tri_in_valid, 1'b1);
        chk("tri_xy", {bus.tri_coord_x, bus.tri_coord_y}, v);
      end else if (k == 4) begin
        chk("tri_in_valid_off", bus.tri_in_valid, 1'b0);
        chk("tri_xy_zero", {bus.tri_coord_x, bus.tri_coord_y}, 10'd0);
      end
      j = k - (4 + lat);
      if (j >= 0 && j < plen && pat[j] && b < 3) begin
        lv = base + 13'(b);
        iv = base + 13'h100 + 13'(b);
        bus.tri_out_valid    = 1'b1;
        bus.tri_out_length   = lv;
        bus.tri_out_incenter = iv;
        el[38-13*b -: 13]    = lv;
        ei[38-13*b -: 13]    = iv;
        b++;
      end else begin
        // junk while FEED runs must be ignored; junk data in gaps too
        bus.tri_out_valid    = (k <= 3);
        bus.tri_out_length   = 13'h1fff;
        bus.tri_out_incenter = 13'h1fff;
      end
      tick();
      k++;
    end
    bus.tri_out_valid = 1'b0;
    chk("rsp_latency", k, exp_k);
    for (int h = 0; h <= hold; h++) begin
      chk("rsp_valid_hold", bus.rsp_valid, 1'b1);
      chk("rsp_id", bus.rsp_id, exp_id);
      chk("rsp_err", bus.rsp_err, exp_err);
      chk("rsp_length", bus.rsp_length, el);
      chk("rsp_incenter", bus.rsp_incenter, ei);
      chk("rq_ready_resp", bus.rq_ready, 2'b00);
      if (h == hold) bus.rsp_ready = 1'b1;
      tick();
    end
    bus.rsp_ready = 1'b0;
    chk("rsp_valid_drop", bus.rsp_valid, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    bus.rq_valid         = 2'b11;
    bus.rq0_coord        = RQ0;
    bus.rq1_coord        = RQ1;
    bus.tri_out_valid    = 1'b0;
    bus.tri_out_length   = '0;
    bus.tri_out_incenter = '0;
    bus.rsp_ready        = 1'b0;

    #1;
    chk_zero_outputs("reset_t0");
    tick();
    tick();
    chk_zero_outputs("reset");
    bus.rq_valid = 2'b00;
    rst_n = 1'b1;
    tick();

    // contention: both valid throughout, alternation starting at requester 0
    job(2'b11, 5'b00111, 3, 4, 11, 1'b0, 1'b0, 0, 13'd9);
    job(2'b11, 5'b00111, 3, 4, 11, 1'b1, 1'b0, 0, 13'd40);
    job(2'b11, 5'b00111, 3, 4, 11, 1'b0, 1'b0, 0, 13'd77);
    job(2'b11, 5'b00111, 3, 4, 11, 1'b1, 1'b0, 0, 13'd500);

    // back-pressure for 20 cycles, then immediate accept in the next IDLE cycle
    job(2'b10, 5'b00111, 3, 2, 9, 1'b1, 1'b0, 20, 13'h0a0);

    // timeout: no output at all, response 16 cycles after entering WAIT
    job(2'b01, 5'b00000, 0, 0, 20, 1'b0, 1'b1, 1, 13'd0);

    // gapped output 1,0,0,1,1
    job(2'b01, 5'b11001, 5, 4, 13, 1'b0, 1'b0, 2, 13'h777);

    // reset during COLLECT after beat 1
    bus.rq_valid = 2'b01;
    #1;
    chk("abort_grant", bus.rq_ready, 2'b01);
    tick();
    bus.rq_valid = 2'b00;
    for (int k = 1; k <= 9; k++) begin
      bus.tri_out_valid    = (k >= 8);
      bus.tri_out_length   = 13'h0123 + 13'(k);
      bus.tri_out_incenter = 13'h0456 + 13'(k);
      tick();
    end
    bus.rq_valid = 2'b01;
    rst_n = 1'b0;
    #1;
    chk_zero_outputs("abort");
    tick();
    bus.rq_valid = 2'b00;
    rst_n = 1'b1;
    for (int k = 0; k < 25; k++) begin
      bus.tri_out_valid = (k < 3);
      tick();
      chk("abort_no_rsp", bus.rsp_valid, 1'b0);
    end
    bus.tri_out_valid = 1'b0;

    // pointer reset favours requester 0 again
    job(2'b11, 5'b00111, 3, 4, 11, 1'b0, 1'b0, 0, 13'd321);
    bus.rq_valid = 2'b00;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/tri_sched.md
TRI_SCHED -- requirements
Module: tri_sched

Interface
REQ-001 SHALL have parameter TIMEOUT, default 1023: max cycles spent in WAIT+COLLECT before job aborts.
REQ-002 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port rq_valid  input  2  per-requester job request (bit0 = requester 0).
REQ-005 SHALL have port rq_ready  output  2  per-requester accept; job taken when rq_valid[i]&rq_ready[i].
REQ-006 SHALL have port rq0_coord  input  30  requester 0 vertices {x0,y0,x1,y1,x2,y2}, 5 bits each, x0 in [29:25].
REQ-007 SHALL have port rq1_coord  input  30  requester 1 vertices, same packing.
REQ-008 SHALL have port tri_in_valid  output  1  drives TRIANGLE in_valid.
REQ-009 SHALL have port tri_coord_x  output  5  drives TRIANGLE coord_x.
REQ-010 SHALL have port tri_coord_y  output  5  drives TRIANGLE coord_y.
REQ-011 SHALL have port tri_out_valid  input  1  TRIANGLE out_valid.
REQ-012 SHALL have port tri_out_length  input  13  TRIANGLE out_length.
REQ-013 SHALL have port tri_out_incenter  input  13  TRIANGLE out_incenter.
REQ-014 SHALL have port rsp_valid  output  1  result available.
REQ-015 SHALL have port rsp_ready  input  1  consumer accepts result.
REQ-016 SHALL have port rsp_id  output  1  requester that owns the result.
REQ-017 SHALL have port rsp_err  output  1  job aborted by timeout.
REQ-018 SHALL have port rsp_length  output  39  three length beats, beat0 in [38:26].
REQ-019 SHALL have port rsp_incenter  output  39  three incenter beats, beat0 in [38:26].

Function
REQ-020 SHALL implement FSM IDLE, FEED, WAIT, COLLECT, RESP; one job in flight at a time.
REQ-021 SHALL in IDLE assert rq_ready only for the granted requester (combinational from rq_valid and rr pointer); rq_ready = 0 in all other states.
REQ-022 SHALL arbitrate round-robin: single requester valid -> granted; both valid -> requester not served last; pointer after reset favours requester 0.
REQ-023 SHALL on accept latch winner coords and id, update rr pointer, go to FEED next cycle.
REQ-024 SHALL in FEED hold tri_in_valid = 1 for exactly 3 consecutive cycles presenting vertex 0, 1, 2 in order, then go to WAIT; tri_coord_x/y = 0 whenever tri_in_valid = 0.
REQ-025 SHALL in WAIT go to COLLECT on the first cycle tri_out_valid = 1, capturing that cycle as beat 0.
REQ-026 SHALL in COLLECT capture one beat of tri_out_length/tri_out_incenter per cycle with tri_out_valid = 1; gaps (tri_out_valid = 0) stall without losing captured beats; after beat 2 go to RESP.
REQ-027 SHALL ignore tri_out_valid in IDLE, FEED and RESP.
REQ-028 SHALL run a timeout counter cleared on entering WAIT, incrementing each cycle in WAIT/COLLECT; on reaching TIMEOUT go to RESP with rsp_err = 1, uncaptured beats reading 0.
REQ-029 SHALL in RESP hold rsp_valid = 1 with stable rsp_id/rsp_err/rsp_length/rsp_incenter until rsp_ready = 1; that cycle return to IDLE.
REQ-030 SHALL not accept a new job in the cycle RESP completes; earliest accept is the following IDLE cycle.
REQ-031 SHALL give minimum latency accept -> rsp_valid of 3 (FEED) + TRIANGLE latency + 3 (COLLECT) + 1 cycles.
REQ-032 SHALL keep rq coords from a non-accepted requester untouched; rq_valid may drop without acceptance with no effect.

Reset
REQ-033 SHALL on rst_n = 0 asynchronously force IDLE, rr pointer to favour requester 0, counters and captured beats to 0, tri_in_valid/tri_coord_x/tri_coord_y/rsp_valid/rsp_id/rsp_err/rsp_length/rsp_incenter = 0; rq_ready = 0 while rst_n = 0.
REQ-034 SHALL on reset mid-job drop the job silently; no response for it after reset release.

Verification
REQ-035 Single job: rq_valid=01, rq0_coord={1,2,10,2,1,12}, TRIANGLE model 4-cycle latency -> tri_in_valid 3 cycles with (1,2),(10,2),(1,12); rsp_valid, rsp_id=0, rsp_err=0, beats match model, 11 cycles after accept.
REQ-036 Contention: rq_valid=11 held for 4 jobs -> served order 0,1,0,1; rq_ready never 11.
REQ-037 Back-pressure: rsp_ready=0 for 20 cycles -> rsp fields stable, rq_ready=00 throughout, accept next IDLE after handshake.
REQ-038 Timeout: TIMEOUT=16, model never asserts out_valid -> rsp_valid with rsp_err=1, lengths/incenters 0, 16 cycles after entering WAIT.
REQ-039 Gapped output: out_valid pattern 1,0,0,1,1 -> three beats captured correctly, rsp_err=0.
REQ-040 Reset in COLLECT after beat 1 -> all outputs 0 immediately, no rsp_valid afterwards, next job served normally.
